control2read: RTL and testbench
===============================

Name: control2read

Overview:
- Read-side counterpart of the buffer write controller.
- On a configuration command, reads a line of packed 32-bit words from the X_MAC×X_MESH buffer bank array and unpacks them into per-lane byte streams for the compute mesh.
- Pooled mode: 1 byte per lane per beat from one MAC bank column. Unpooled mode: 2×2 bytes per lane per beat from two adjacent columns.
- Word packing is identical to the writer's, so a written line reads back unchanged.

Parameters:
- X_MAC, 4, MAC bank columns (logic supports exactly 4).
- X_MESH, 16, mesh lanes (bank rows).
- ADDR_LEN, 13, bank address width.
- DATA_LEN, 32, bank word width.
- MAX_LINE_LEN, 10, width of linelen.
- RD_LAT, 1, bank read latency in cycles (1..3).
- FIFO_DEPTH, 4, prefetch word FIFO depth; must be ≥ RD_LAT+2.
- BUFFER_NUM, X_MAC*X_MESH, bank count.
- ADDRWIDTH / DATAWIDTH, BUFFER_NUM*ADDR_LEN / BUFFER_NUM*DATA_LEN, flattened bus widths.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- conf_input  in  1  start pulse; samples the configuration inputs below.
- st_addr  in  ADDR_LEN*X_MAC  start address per MAC column; column j at [j*ADDR_LEN+:ADDR_LEN].
- linelen  in  MAX_LINE_LEN  element count per lane.
- valid_mac  in  2  selected MAC column.
- pooled  in  1  1 = byte mode, 0 = pair mode.
- addrb  out  ADDRWIDTH  bank addresses; bank (row i, col j) at [(i*X_MAC+j)*ADDR_LEN+:ADDR_LEN].
- enb  out  BUFFER_NUM  bank read enables, bit i*X_MAC+j.
- doutb  in  DATAWIDTH  bank read data, same indexing as addrb.
- out_data_1  out  8*X_MESH  pooled byte for lane i at [8i+:8].
- out_data_4  out  32*X_MESH  unpooled bytes; lane i, column-slot jj, element k at [8*(k+2jj+4i)+:8].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- busy  out  1  line in progress.
- idle  out  1  !busy and FIFO empty.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- **Reset values:** out_valid=0, enb=0, addrb=0, out_data_*=0, busy=0, done=0, idle=1. All in-flight read data is discarded, FIFO is emptied and the latency pipe is cleared. Reset takes effect mid-line.
- **Configuration:** conf_input while !busy latches all config inputs and sets busy next cycle. conf_input while busy is ignored.
- **Columns:**
  - Pooled: column c0=valid_mac only.
  - Unpooled: c0=valid_mac and c1=(valid_mac+1) mod 4; valid_mac=3 pairs columns 3 and 0.
  - Enables are asserted in all X_MESH rows of the active columns; other enb bits are 0.
- **Read count and addressing:**
  - Word reads per column W = ceil(linelen/4).
  - Column j reads st_addr_j, st_addr_j+1, …; addresses wrap modulo 2^ADDR_LEN.
  - Inactive columns hold their address.
- **Issue rule:** a read is issued (enb high for one cycle) when reads_issued<W and (in_flight + fifo_count) < FIFO_DEPTH. Return data is pushed into the FIFO RD_LAT cycles after issue. Back-to-back issue is sustained at one word per cycle.
- **Unpack, pooled:**
  - Each FIFO word gives beats k=0..3; out_data_1 lane i = word_i[8k+:8].
  - Word popped after beat 3 or after the final element.
  - Total beats = linelen.
- **Unpack, unpooled:**
  - Each word pair gives beat 0 (bits [15:0]) then beat 1 (bits [31:16]).
  - jj=0 from c0, jj=1 from c1.
  - Total beats = ceil(linelen/2).
  - If linelen is odd, the last beat's k=1 bytes are driven 0.
- **Handshake:** out_valid stays high with out_data stable until out_valid&&out_ready. Zero-bubble: a new beat is presented the cycle after acceptance if data is present.
- **Completion:** on acceptance of the final beat, busy→0 and done=1 for one cycle.
- **Zero-length line:** linelen=0 issues no reads, gives no out_valid, and done pulses the cycle after busy rises.
- **State machine:** IDLE → RUN (issue/unpack) → DRAIN (all reads issued, FIFO emptying) → IDLE. RUN goes directly to IDLE if the last beat is accepted in the same cycle as the last issue completes.

Optional Feature:
- CONTROL2READ_DOUT_REG_EN.
- Defined: doutb is captured in a register before the FIFO. Effective latency is RD_LAT+1, the credit count includes this stage, and the FIFO_DEPTH requirement becomes ≥ RD_LAT+3.
- Undefined: doutb enters the FIFO directly at latency RD_LAT.

Test Plan:
- Pooled read: valid_mac=1, st_addr col1=0x010, linelen=6, words 0x44332211 @0x010 and 0x00006655 @0x011, out_ready=1 → reads 0x010 and 0x011 on col1 only. Beats 0x11,0x22,0x33,0x44,0x55,0x66 are consecutive, then done.
- Unpooled wrap: valid_mac=3, linelen=3, col3 word 0xDDCCBBAA, col0 word 0x44332211 → beat 0 gives lane bytes {AA,BB,11,22}, beat 1 gives {CC,00,33,00}. enb is set on columns 3 and 0 only.
- Backpressure: pooled, linelen=16, out_ready toggling 1/0 → no beat dropped or duplicated, outstanding reads ≤ FIFO_DEPTH, data held stable while stalled.
- Address wrap: st_addr=0x1FFF, linelen=8 pooled → reads 0x1FFF then 0x0000.
- linelen=0 → no enb activity, done pulses once; conf_input asserted mid-line → ignored, line completes unchanged.
- rst asserted mid-line with reads in flight → next cycle all outputs are at reset values, and a fresh line afterwards contains no stale bytes.

Source files
------------

// File: rtl/control2read.sv
// control2read: reads packed 32-bit lines from the X_MAC x X_MESH bank array and unpacks them
// into per-lane byte beats. Optional doutb capture stage: `define CONTROL2READ_DOUT_REG_EN.
module control2read #(
  parameter int X_MAC        = 4,
  parameter int X_MESH       = 16,
  parameter int ADDR_LEN     = 13,
  parameter int DATA_LEN     = 32,
  parameter int MAX_LINE_LEN = 10,
  parameter int RD_LAT       = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int BUFFER_NUM   = X_MAC * X_MESH,
  parameter int ADDRWIDTH    = BUFFER_NUM * ADDR_LEN,
  parameter int DATAWIDTH    = BUFFER_NUM * DATA_LEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        conf_input,
  input  logic [ADDR_LEN*X_MAC-1:0]   st_addr,
  input  logic [MAX_LINE_LEN-1:0]     linelen,
  input  logic [1:0]                  valid_mac,
  input  logic                        pooled,
  output logic [ADDRWIDTH-1:0]        addrb,
  output logic [BUFFER_NUM-1:0]       enb,
  input  logic [DATAWIDTH-1:0]        doutb,
  output logic [8*X_MESH-1:0]         out_data_1,
  output logic [32*X_MESH-1:0]        out_data_4,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        idle,
  output logic                        done
);
  // state   | meaning
  // S_IDLE  | waiting for conf_input
  // S_RUN   | issuing bank reads and unpacking beats
  // S_DRAIN | all reads issued, FIFO emptying
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam int LW      = MAX_LINE_LEN;
  localparam int ENTRY_W = 2 * X_MESH * DATA_LEN;
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);

  state_t state_q, state_d;
  logic [ADDR_LEN-1:0] addr_q [X_MAC];
  logic [LW-1:0]       len_q, rd_cnt_q, beat_q;
  logic [1:0]          c0_q, c1_q;
  logic                pooled_q, done_q;
  logic [RD_LAT-1:0]   pipe_q;
  logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       cnt_q;

  logic [LW:0]         len_p3, len_p1;
  logic [LW-1:0]       w_total, n_beats;
  logic [1:0]          vm_next;
  logic                conf_accept, issue_en, stream_en, issue, accept, last_beat, pop, push, finish;
  logic                stage_busy;
  logic [ENTRY_W-1:0]  sel_in, fifo_in, head;
  int                  credit;

  assign len_p3      = {1'b0, len_q} + (LW+1)'(3);
  assign len_p1      = {1'b0, len_q} + (LW+1)'(1);
  assign w_total     = LW'(len_p3 >> 2);
  assign n_beats     = pooled_q ? len_q : LW'(len_p1 >> 1);
  assign vm_next     = valid_mac + 2'd1;
  assign conf_accept = (state_q == S_IDLE) && conf_input;

  // Outstanding reads (latency pipe, capture stage) plus stored words bound the FIFO fill.
  always_comb begin
    credit = int'(cnt_q) + int'(stage_busy);
    for (int i = 0; i < RD_LAT; i++) credit += int'(pipe_q[i]);
  end

  assign issue     = issue_en && (rd_cnt_q < w_total) && (credit < FIFO_DEPTH);
  assign out_valid = stream_en && (cnt_q != '0) && (beat_q < n_beats);
  assign accept    = out_valid && out_ready;
  assign last_beat = (beat_q == n_beats - LW'(1));
  assign pop       = accept && (last_beat || (pooled_q ? (beat_q[1:0] == 2'd3) : beat_q[0]));
  assign finish    = (accept && last_beat) || (issue_en && (n_beats == '0));
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    sel_in = '0;
    for (int i = 0; i < X_MESH; i++) begin
      sel_in[i*DATA_LEN +: DATA_LEN]          = doutb[(i*X_MAC + int'(c0_q))*DATA_LEN +: DATA_LEN];
      sel_in[(X_MESH+i)*DATA_LEN +: DATA_LEN] = doutb[(i*X_MAC + int'(c1_q))*DATA_LEN +: DATA_LEN];
    end
  end

`ifdef CONTROL2READ_DOUT_REG_EN
  logic               dreg_v;
  logic [ENTRY_W-1:0] dreg_d;
  always_ff @(posedge clk) begin
    if (rst) dreg_v <= 1'b0;
    else     dreg_v <= pipe_q[RD_LAT-1];
  end
  always_ff @(posedge clk) begin
    if (pipe_q[RD_LAT-1]) dreg_d <= sel_in;
  end
  assign push       = dreg_v;
  assign fifo_in    = dreg_d;
  assign stage_busy = dreg_v;
`else
  assign push       = pipe_q[RD_LAT-1];
  assign fifo_in    = sel_in;
  assign stage_busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (conf_input) state_d = S_RUN;
      S_RUN: begin
        if (finish) state_d = S_IDLE;
        else if ((rd_cnt_q + LW'(issue)) == w_total) state_d = S_DRAIN;
      end
      S_DRAIN: if (finish) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    issue_en  = (state_q == S_RUN);
    stream_en = (state_q != S_IDLE);
    idle      = (state_q == S_IDLE) && (cnt_q == '0);
    done      = done_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < X_MAC; j++) addr_q[j] <= '0;
      len_q    <= '0;
      rd_cnt_q <= '0;
      beat_q   <= '0;
      c0_q     <= '0;
      c1_q     <= '0;
      pooled_q <= 1'b0;
      done_q   <= 1'b0;
      pipe_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      done_q    <= finish;
      pipe_q[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      if (conf_accept) begin
        len_q    <= linelen;
        c0_q     <= valid_mac;
        c1_q     <= vm_next;
        pooled_q <= pooled;
        rd_cnt_q <= '0;
        beat_q   <= '0;
        for (int j = 0; j < X_MAC; j++)
          if ((2'(j) == valid_mac) || (!pooled && (2'(j) == vm_next)))
            addr_q[j] <= st_addr[j*ADDR_LEN +: ADDR_LEN];
      end else begin
        if (issue) begin
          rd_cnt_q <= rd_cnt_q + LW'(1);
          for (int j = 0; j < X_MAC; j++)
            if ((2'(j) == c0_q) || (!pooled_q && (2'(j) == c1_q)))
              addr_q[j] <= addr_q[j] + ADDR_LEN'(1);
        end
        if (accept) beat_q <= beat_q + LW'(1);
      end
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= fifo_in;
  end

  always_comb begin
    enb   = '0;
    addrb = '0;
    for (int i = 0; i < X_MESH; i++)
      for (int j = 0; j < X_MAC; j++) begin
        addrb[(i*X_MAC+j)*ADDR_LEN +: ADDR_LEN] = addr_q[j];
        enb[i*X_MAC+j] = issue && ((2'(j) == c0_q) || (!pooled_q && (2'(j) == c1_q)));
      end
  end

  // Odd-length pair lines blank the k=1 bytes of the final beat.
  always_comb begin
    out_data_1 = '0;
    out_data_4 = '0;
    if (out_valid) begin
      for (int i = 0; i < X_MESH; i++) begin
        if (pooled_q)
          out_data_1[8*i +: 8] = head[i*DATA_LEN + 8*int'(beat_q[1:0]) +: 8];
        else
          for (int jj = 0; jj < 2; jj++)
            for (int k = 0; k < 2; k++)
              if (!(k == 1 && last_beat && len_q[0]))
                out_data_4[8*(k+2*jj+4*i) +: 8] =
                  head[(jj*X_MESH+i)*DATA_LEN + 16*int'(beat_q[0]) + 8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_control2read.sv
// Self-checking bench for control2read: bank memory model, beat monitor and a line-level
// reference model computed from element indices.
module tb_control2read;
  localparam int X_MAC = 4, X_MESH = 16, AL = 13, FD = 4, NB = X_MAC * X_MESH;

  logic clk = 1'b0;
  logic rst, conf_input, pooled, out_ready;
  logic [AL*X_MAC-1:0] st_addr;
  logic [9:0] linelen;
  logic [1:0] valid_mac;
  logic [NB*AL-1:0] addrb;
  logic [NB-1:0] enb;
  logic [NB*32-1:0] doutb = '0;
  logic [8*X_MESH-1:0] out_data_1;
  logic [32*X_MESH-1:0] out_data_4;
  logic out_valid, busy, idle, done;

  always #5 clk = ~clk;

  control2read dut (
    .clk(clk), .rst(rst), .conf_input(conf_input), .st_addr(st_addr), .linelen(linelen),
    .valid_mac(valid_mac), .pooled(pooled), .addrb(addrb), .enb(enb), .doutb(doutb),
    .out_data_1(out_data_1), .out_data_4(out_data_4), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .idle(idle), .done(done)
  );

  int total = 0, bad = 0;

  // Bank contents: per-(column,address) overrides, otherwise a hash of row/col/address.
  logic [31:0] ovr [int];
  logic [31:0] mseed = 32'h1234_5678;

  function automatic logic [31:0] mem_word(int row, int col, logic [12:0] a);
    int key = col * 8192 + int'(a);
    if (ovr.exists(key)) return ovr[key];
    return ((32'(a) * 32'h9E37_79B1) ^ (32'(row) << 24) ^ (32'(col) << 18) ^ mseed)
           * 32'h85EB_CA6B + 32'(row);
  endfunction

  logic [NB-1:0] en_s = '0;
  logic [NB*AL-1:0] ad_s = '0;
  always @(negedge clk) begin
    en_s = enb;
    ad_s = addrb;
  end
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (en_s[b]) doutb[b*32 +: 32] <= mem_word(b / X_MAC, b % X_MAC, ad_s[b*AL +: AL]);
  end

  // Monitor: collects accepted beats, issued addresses and protocol violations.
  logic [8*X_MESH-1:0] act1[$];
  logic [32*X_MESH-1:0] act4[$];
  logic [12:0] aq0[$], aq1[$];
  int cyc = 0, acc_first = -1, acc_last = -1, done_cnt = 0, done_cyc = -1, conf_cyc = -1;
  int bad_enb = 0, bad_stall = 0, bad_out = 0, issued = 0;
  logic m_pooled = 1'b1;
  logic [1:0] m_c0 = '0, m_c1 = '0;
  logic pv = 1'b0, pr = 1'b0;
  logic [8*X_MESH-1:0] p1 = '0;
  logic [32*X_MESH-1:0] p4 = '0;

  always @(negedge clk) begin : mon
    logic [NB-1:0] mask;
    int consumed;
    cyc++;
    if (rst) begin
      act1.delete(); act4.delete(); aq0.delete(); aq1.delete();
      acc_first = -1; acc_last = -1; done_cnt = 0; done_cyc = -1;
      bad_enb = 0; bad_stall = 0; bad_out = 0; issued = 0; pv = 1'b0;
    end else begin
      if (conf_input && !busy) begin
        act1.delete(); act4.delete(); aq0.delete(); aq1.delete();
        acc_first = -1; acc_last = -1; done_cnt = 0; done_cyc = -1;
        bad_enb = 0; bad_stall = 0; bad_out = 0; issued = 0;
        conf_cyc = cyc; m_pooled = pooled; m_c0 = valid_mac; m_c1 = valid_mac + 2'd1;
      end
      if (pv && !pr && (!out_valid || out_data_1 !== p1 || out_data_4 !== p4)) bad_stall++;
      if (enb != '0) begin
        mask = '0;
        for (int i = 0; i < X_MESH; i++) begin
          mask[i*X_MAC + int'(m_c0)] = 1'b1;
          if (!m_pooled) mask[i*X_MAC + int'(m_c1)] = 1'b1;
          if (addrb[(i*X_MAC + int'(m_c0))*AL +: AL] !== addrb[int'(m_c0)*AL +: AL]) bad_enb++;
        end
        if (enb !== mask) bad_enb++;
        aq0.push_back(addrb[int'(m_c0)*AL +: AL]);
        if (!m_pooled) aq1.push_back(addrb[int'(m_c1)*AL +: AL]);
        issued++;
        consumed = m_pooled ? act1.size() / 4 : act1.size() / 2;
        if (issued - consumed > FD) bad_out++;
      end
      if (out_valid && out_ready) begin
        act1.push_back(out_data_1);
        act4.push_back(out_data_4);
        if (acc_first < 0) acc_first = cyc;
        acc_last = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      pv = out_valid; pr = out_ready; p1 = out_data_1; p4 = out_data_4;
    end
  end

  // Reference model: expected beats and per-column address sequences for one line.
  logic [8*X_MESH-1:0] exp1[$];
  logic [32*X_MESH-1:0] exp4[$];
  logic [12:0] ea0[$], ea1[$];

  task automatic build_exp(input logic pl, input logic [1:0] vm, input logic [AL*X_MAC-1:0] sa,
                           input int len);
    logic [1:0] cols [2];
    logic [12:0] base, a;
    logic [31:0] w;
    logic [8*X_MESH-1:0] v1;
    logic [32*X_MESH-1:0] v4;
    int nb, e;
    cols[0] = vm;
    cols[1] = vm + 2'd1;
    nb = pl ? len : (len + 1) / 2;
    exp1.delete(); exp4.delete(); ea0.delete(); ea1.delete();
    for (int n = 0; n < (len + 3) / 4; n++) begin
      ea0.push_back(sa[int'(cols[0])*AL +: AL] + 13'(n));
      if (!pl) ea1.push_back(sa[int'(cols[1])*AL +: AL] + 13'(n));
    end
    for (int b = 0; b < nb; b++) begin
      v1 = '0;
      v4 = '0;
      for (int ln = 0; ln < X_MESH; ln++) begin
        if (pl) begin
          base = sa[int'(cols[0])*AL +: AL];
          a = base + 13'(b / 4);
          w = mem_word(ln, int'(cols[0]), a);
          v1[8*ln +: 8] = w[8*(b%4) +: 8];
        end else begin
          for (int jj = 0; jj < 2; jj++)
            for (int k = 0; k < 2; k++) begin
              e = 2 * b + k;
              if (e < len) begin
                base = sa[int'(cols[jj])*AL +: AL];
                a = base + 13'(e / 4);
                w = mem_word(ln, int'(cols[jj]), a);
                v4[8*(k + 2*jj + 4*ln) +: 8] = w[8*(e%4) +: 8];
              end
            end
        end
      end
      if (pl) exp1.push_back(v1);
      else exp4.push_back(v4);
    end
  endtask

  // Start one line and wait (bounded) for done. rmode: 0 ready, 1 toggling, 2 random.
  task automatic run_line(input logic pl, input logic [1:0] vm, input logic [AL*X_MAC-1:0] sa,
                          input int len, input int rmode, input int glitch, output int timeout);
    build_exp(pl, vm, sa, len);
    @(posedge clk); #1;
    conf_input = 1'b1; pooled = pl; valid_mac = vm; st_addr = sa; linelen = 10'(len);
    out_ready = 1'b1;
    @(posedge clk); #1;
    conf_input = 1'b0; pooled = $urandom_range(0, 1) == 1; valid_mac = 2'($urandom);
    st_addr = {$urandom, $urandom}; linelen = 10'($urandom);
    timeout = 1;
    for (int c = 0; c < 3000; c++) begin
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? c[0] : ($urandom_range(0, 1) == 1);
      conf_input = (c == glitch);
      if (c == glitch) begin
        pooled = ~pl; valid_mac = vm + 2'd2; linelen = 10'd5; st_addr = {$urandom, $urandom};
      end
      if (done_cnt > 0) begin
        timeout = 0;
        break;
      end
      @(posedge clk); #1;
    end
    conf_input = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; conf_input = 1'b0; pooled = 1'b1; out_ready = 1'b1;
    st_addr = '0; linelen = '0; valid_mac = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (enb !== '0) begin bad++; $display("FAIL reset_enb got=%h want=0", enb); end
    total++; if (addrb !== '0) begin bad++; $display("FAIL reset_addrb got=%h want=0", addrb); end
    total++; if (out_data_1 !== '0 || out_data_4 !== '0) begin bad++; $display("FAIL reset_out_data got=%h/%h want=0", out_data_1, out_data_4); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b want=00", busy, done); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", idle); end
  endtask

  task automatic test_pooled;
    logic [AL*X_MAC-1:0] sa;
    int to;
    ovr.delete();
    ovr[1*8192 + 16'h010] = 32'h4433_2211;
    ovr[1*8192 + 16'h011] = 32'h0000_6655;
    sa = {$urandom, $urandom};
    sa[1*AL +: AL] = 13'h010;
    run_line(1'b1, 2'd1, sa, 6, 0, -1, to);
    total++; if (to !== 0) begin bad++; $display("FAIL pooled_timeout got=%0d want=0", to); end
    total++; if (act1.size() !== 6) begin bad++; $display("FAIL pooled_beats got=%0d want=6", act1.size()); end
    for (int b = 0; b < act1.size() && b < exp1.size(); b++) begin
      total++; if (act1[b] !== exp1[b]) begin bad++; $display("FAIL pooled_beat%0d got=%h want=%h", b, act1[b], exp1[b]); end
    end
    if (act1.size() == 6) begin
      total++; if (act1[0][7:0] !== 8'h11 || act1[5][127:120] !== 8'h66) begin bad++; $display("FAIL pooled_bytes got=%h,%h want=11,66", act1[0][7:0], act1[5][127:120]); end
    end
    total++; if (aq0.size() !== 2) begin bad++; $display("FAIL pooled_reads got=%0d want=2", aq0.size()); end
    if (aq0.size() == 2) begin
      total++; if (aq0[0] !== 13'h010 || aq0[1] !== 13'h011) begin bad++; $display("FAIL pooled_addr got=%h,%h want=010,011", aq0[0], aq0[1]); end
    end
    total++; if (bad_enb !== 0) begin bad++; $display("FAIL pooled_enb got=%0d want=0", bad_enb); end
    total++; if (acc_last - acc_first !== 5) begin bad++; $display("FAIL pooled_consecutive got=%0d want=5", acc_last - acc_first); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL pooled_done got=%0d want=1", done_cnt); end
    total++; if (busy !== 1'b0 || idle !== 1'b1) begin bad++; $display("FAIL pooled_end_state got=busy%b idle%b want=busy0 idle1", busy, idle); end
  endtask

  task automatic test_unpooled_wrap;
    logic [AL*X_MAC-1:0] sa;
    int to;
    ovr.delete();
    sa = {$urandom, $urandom};
    sa[3*AL +: AL] = 13'h100;
    sa[0*AL +: AL] = 13'h200;
    ovr[3*8192 + 16'h100] = 32'hDDCC_BBAA;
    ovr[0*8192 + 16'h200] = 32'h4433_2211;
    run_line(1'b0, 2'd3, sa, 3, 0, -1, to);
    total++; if (to !== 0) begin bad++; $display("FAIL unpooled_timeout got=%0d want=0", to); end
    total++; if (act4.size() !== 2) begin bad++; $display("FAIL unpooled_beats got=%0d want=2", act4.size()); end
    if (act4.size() == 2) begin
      total++; if (act4[0][31:0] !== 32'h2211_BBAA) begin bad++; $display("FAIL unpooled_beat0 got=%h want=2211bbaa", act4[0][31:0]); end
      total++; if (act4[1][31:0] !== 32'h0033_00CC) begin bad++; $display("FAIL unpooled_beat1 got=%h want=003300cc", act4[1][31:0]); end
      total++; if (act4[0] !== exp4[0] || act4[1] !== exp4[1]) begin bad++; $display("FAIL unpooled_lanes got=%h want=%h", act4[1], exp4[1]); end
    end
    total++; if (aq0.size() !== 1 || aq1.size() !== 1) begin bad++; $display("FAIL unpooled_reads got=%0d/%0d want=1/1", aq0.size(), aq1.size()); end
    total++; if (bad_enb !== 0) begin bad++; $display("FAIL unpooled_enb got=%0d want=0", bad_enb); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL unpooled_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_backpressure;
    logic [AL*X_MAC-1:0] sa;
    int to;
    ovr.delete();
    sa = {$urandom, $urandom};
    run_line(1'b1, 2'($urandom), sa, 16, 1, -1, to);
    total++; if (to !== 0) begin bad++; $display("FAIL bp_timeout got=%0d want=0", to); end
    total++; if (act1.size() !== 16) begin bad++; $display("FAIL bp_beats got=%0d want=16", act1.size()); end
    for (int b = 0; b < act1.size() && b < exp1.size(); b++) begin
      total++; if (act1[b] !== exp1[b]) begin bad++; $display("FAIL bp_beat%0d got=%h want=%h", b, act1[b], exp1[b]); end
    end
    total++; if (bad_stall !== 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", bad_stall); end
    total++; if (bad_out !== 0) begin bad++; $display("FAIL bp_outstanding got=%0d want=0", bad_out); end
    total++; if (aq0 != ea0) begin bad++; $display("FAIL bp_addr got=%0d reads want=%0d", aq0.size(), ea0.size()); end
  endtask

  task automatic test_addr_wrap;
    logic [AL*X_MAC-1:0] sa;
    int to;
    ovr.delete();
    sa = {$urandom, $urandom};
    sa[2*AL +: AL] = 13'h1FFF;
    run_line(1'b1, 2'd2, sa, 8, 0, -1, to);
    total++; if (aq0.size() !== 2) begin bad++; $display("FAIL wrap_reads got=%0d want=2", aq0.size()); end
    if (aq0.size() == 2) begin
      total++; if (aq0[0] !== 13'h1FFF || aq0[1] !== 13'h0000) begin bad++; $display("FAIL wrap_addr got=%h,%h want=1fff,0000", aq0[0], aq0[1]); end
    end
    total++; if (act1 != exp1) begin bad++; $display("FAIL wrap_data got=%0d beats want=%0d", act1.size(), exp1.size()); end
  endtask

  task automatic test_zero_len;
    int to;
    run_line(1'b0, 2'($urandom), {$urandom, $urandom}, 0, 0, -1, to);
    total++; if (issued !== 0) begin bad++; $display("FAIL zero_reads got=%0d want=0", issued); end
    total++; if (act1.size() !== 0) begin bad++; $display("FAIL zero_beats got=%0d want=0", act1.size()); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL zero_done got=%0d want=1", done_cnt); end
    total++; if (done_cyc - conf_cyc !== 2) begin bad++; $display("FAIL zero_done_time got=%0d want=2", done_cyc - conf_cyc); end
  endtask

  task automatic test_conf_ignored;
    logic [AL*X_MAC-1:0] sa;
    int to;
    ovr.delete();
    sa = {$urandom, $urandom};
    run_line(1'b1, 2'd0, sa, 12, 0, 3, to);
    total++; if (to !== 0) begin bad++; $display("FAIL ignore_timeout got=%0d want=0", to); end
    total++; if (act1 != exp1) begin bad++; $display("FAIL ignore_data got=%0d beats want=%0d", act1.size(), exp1.size()); end
    total++; if (aq0 != ea0 || aq1.size() !== 0) begin bad++; $display("FAIL ignore_addr got=%0d/%0d want=%0d/0", aq0.size(), aq1.size(), ea0.size()); end
    total++; if (done_cnt !== 1 || bad_enb !== 0) begin bad++; $display("FAIL ignore_done got=%0d/%0d want=1/0", done_cnt, bad_enb); end
  endtask

  task automatic test_reset_midline;
    logic [AL*X_MAC-1:0] sa;
    int to;
    ovr.delete();
    @(posedge clk); #1;
    conf_input = 1'b1; pooled = 1'b0; valid_mac = 2'd1; st_addr = {$urandom, $urandom};
    linelen = 10'd40; out_ready = 1'b0;
    @(posedge clk); #1;
    conf_input = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    total++; if (out_valid !== 1'b0 || enb !== '0 || addrb !== '0) begin bad++; $display("FAIL midrst_outputs got=%b/%h want=0/0", out_valid, enb); end
    total++; if (busy !== 1'b0 || done !== 1'b0 || idle !== 1'b1) begin bad++; $display("FAIL midrst_status got=%b%b%b want=001", busy, done, idle); end
    total++; if (out_data_1 !== '0 || out_data_4 !== '0) begin bad++; $display("FAIL midrst_data got=%h want=0", out_data_4); end
    mseed = mseed ^ 32'hA5A5_0F0F;
    sa = {$urandom, $urandom};
    run_line(1'b0, 2'd1, sa, 9, 0, -1, to);
    total++; if (act4 != exp4) begin bad++; $display("FAIL midrst_fresh got=%0d beats want=%0d", act4.size(), exp4.size()); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL midrst_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_random;
    logic [AL*X_MAC-1:0] sa;
    logic pl;
    int len, to;
    ovr.delete();
    for (int it = 0; it < 12; it++) begin
      mseed = $urandom;
      sa = {$urandom, $urandom};
      pl = $urandom_range(0, 1) == 1;
      len = (it < 3) ? it + 1 : $urandom_range(0, 40);
      run_line(pl, 2'($urandom), sa, len, 2, -1, to);
      total++; if (to !== 0) begin bad++; $display("FAIL rand%0d_timeout got=%0d want=0", it, to); end
      if (pl) begin
        total++; if (act1 != exp1) begin bad++; $display("FAIL rand%0d_data got=%0d beats want=%0d", it, act1.size(), exp1.size()); end
      end else begin
        total++; if (act4 != exp4) begin bad++; $display("FAIL rand%0d_data got=%0d beats want=%0d", it, act4.size(), exp4.size()); end
      end
      total++; if (aq0 != ea0 || aq1 != ea1) begin bad++; $display("FAIL rand%0d_addr got=%0d/%0d want=%0d/%0d", it, aq0.size(), aq1.size(), ea0.size(), ea1.size()); end
      total++; if (bad_stall + bad_out + bad_enb !== 0) begin bad++; $display("FAIL rand%0d_protocol got=%0d/%0d/%0d want=0", it, bad_stall, bad_out, bad_enb); end
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL rand%0d_done got=%0d want=1", it, done_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_pooled();
    test_unpooled_wrap();
    test_backpressure();
    test_addr_wrap();
    test_zero_len();
    test_conf_ignored();
    test_reset_midline();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
